// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Carry-in that turns A + ~B into two's-complement A - B.
    localparam logic SUB_CARRY_INIT = 1'b1;

    function automatic int cnt_width(input int nbits);
        return (nbits < 2) ? 1 : $clog2(nbits);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit combinational full adder, the only arithmetic in the serial adder.
module serial_fa_cell (
    input  logic in0,
    input  logic in1,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = in0 ^ in1 ^ cin;
    assign cout = (in0 & in1) | (cin & (in0 ^ in1));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over NBITS cycles.
// Optional subtract mode (req_sub port) enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             req_sub,
`endif
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_sum,
    output logic             resp_cout
);

    localparam int CW = cnt_width(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBITS - 1);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [NBITS-1:0] a_sr;
    logic [NBITS-1:0] b_sr;
    logic [NBITS-1:0] sum_sr;
    logic             carry;
    logic             cell_sum;
    logic             cell_cout;
    logic             sub_sel;
    logic             carry_init;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = req_sub;
`else
    assign sub_sel = 1'b0;
`endif
    assign carry_init = sub_sel ? SUB_CARRY_INIT : 1'b0;

    // B is inverted once at load so the cell sees ~B[i] for every bit of a subtract.
    serial_fa_cell u_cell (
        .in0  (a_sr[0]),
        .in1  (b_sr[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        a_sr   <= req_a;
                        b_sr   <= sub_sel ? ~req_b : req_b;
                        sum_sr <= '0;
                        carry  <= carry_init;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    sum_sr <= {cell_sum, sum_sr[NBITS-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= cell_cout;
                    // Hold the counter on the last bit so it never wraps.
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_rdy   = (state == IDLE);
    assign resp_val  = (state == DONE);
    assign resp_sum  = sum_sr;
    assign resp_cout = carry;

endmodule
